// File: rtl/mmss_counter_pkg.sv
// Shared constants for the mm:ss stopwatch time base.
package mmss_counter_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned BCD_MAX     = 9;
    localparam int unsigned SEC_LIMIT_D = 59;
    localparam int unsigned MIN_LIMIT_D = 59;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/bcd_mod_pair.sv
// Two-digit BCD counter that wraps from LIMIT back to 00.
// at_limit is combinational so the parent can build carries in the same cycle.
module bcd_mod_pair
    import mmss_counter_pkg::*;
#(
    parameter int unsigned LIMIT = SEC_LIMIT_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             at_limit
);

    localparam logic [BCD_W-1:0] TENS_LIM = BCD_W'(LIMIT / 10);
    localparam logic [BCD_W-1:0] ONES_LIM = BCD_W'(LIMIT % 10);
    localparam logic [BCD_W-1:0] ONES_MAX = BCD_W'(BCD_MAX);

    logic [BCD_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0] ones_q, ones_d;

    assign at_limit = (tens_q == TENS_LIM) && (ones_q == ONES_LIM);
    assign tens     = tens_q;
    assign ones     = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (at_limit) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == ONES_MAX) begin
                tens_d = tens_q + 1'b1;
                ones_d = '0;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/mmss_counter.sv
// Minutes:seconds BCD time base with run, pause, clear and 2 Hz field adjust.
module mmss_counter
    import mmss_counter_pkg::*;
#(
    parameter int unsigned MIN_LIMIT = MIN_LIMIT_D,
    parameter int unsigned SEC_LIMIT = SEC_LIMIT_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       clr,
    input  logic       pause_pulse,
    input  logic       sel,
    input  logic       adj,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       wrap
);

    logic paused_q, paused_d;
    logic wrap_q, wrap_d;
    logic run_inc, sec_inc, min_inc;
    logic sec_at_limit, min_at_limit;

    // Run counting uses the pre-toggle paused value, so a coincident pause press
    // does not swallow the tick.
    assign run_inc = !adj && tick_1hz && !paused_q;

    always_comb begin
        sec_inc  = run_inc;
        min_inc  = run_inc && sec_at_limit;
        paused_d = paused_q;
        wrap_d   = 1'b0;
        if (adj) begin
            sec_inc = tick_2hz && (sel == SEL_SEC);
            min_inc = tick_2hz && (sel == SEL_MIN);
        end
        if (clr) begin
            paused_d = 1'b0;
        end else begin
            if (pause_pulse) begin
                paused_d = !paused_q;
            end
            wrap_d = run_inc && sec_at_limit && min_at_limit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paused_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            paused_q <= paused_d;
            wrap_q   <= wrap_d;
        end
    end

    bcd_mod_pair #(
        .LIMIT(SEC_LIMIT)
    ) u_sec (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (sec_inc),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .at_limit(sec_at_limit)
    );

    bcd_mod_pair #(
        .LIMIT(MIN_LIMIT)
    ) u_min (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .inc     (min_inc),
        .tens    (min_tens),
        .ones    (min_ones),
        .at_limit(min_at_limit)
    );

    assign paused = paused_q;
    assign wrap   = wrap_q;

endmodule
